// File: rtl/mr_wb_sram_if.sv
// Wishbone pipelined bus bundle between a master and the mr_wb_sram slave.
// AW is the word-address width, normally XLEN minus log2 of the bytes per word.
interface mr_wb_sram_if #(
  parameter int XLEN = 32,
  parameter int AW   = 30
);
  logic              cyc_i;
  logic              stb_i;
  logic              we_i;
  logic [AW-1:0]     addr_i;
  logic [XLEN/8-1:0] sel_i;
  logic [XLEN-1:0]   dat_i;
  logic              ack_o;
  logic              err_o;
  logic              stall_o;
  logic [XLEN-1:0]   dat_o;

  modport master (
    output cyc_i, stb_i, we_i, addr_i, sel_i, dat_i,
    input  ack_o, err_o, stall_o, dat_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, addr_i, sel_i, dat_i,
    output ack_o, err_o, stall_o, dat_o
  );
endinterface

// File: rtl/mr_wb_sram.sv
// Wishbone pipelined SRAM slave: fixed-latency in-order responses, byte-lane writes,
// out-of-range error responses and cycle abort on cyc_i low.
module mr_wb_sram #(
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2,
  parameter int XLEN            = 32
) (
  input logic           clk,
  input logic           rst,
  mr_wb_sram_if.slave   bus
);
  localparam int XLEN_GRAN = $clog2(XLEN / 8);
  localparam int ADDR_W    = XLEN - XLEN_GRAN;
  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int LANES     = XLEN / 8;
  localparam int CW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH_WORDS);
  localparam logic [CW-1:0]   MAX_L   = CW'(MAX_OUTSTANDING);

  logic [XLEN-1:0]    mem [DEPTH_WORDS];

  logic [LATENCY-1:0] p_vld;
  logic [LATENCY-1:0] p_err;
  logic [LATENCY-1:0] p_rd;
  logic [XLEN-1:0]    p_dat [LATENCY];

  logic [CW-1:0]      count;
  logic               resp;
  logic               accept;
  logic               in_range;
  logic [IDX_W-1:0]   idx;

  assign in_range = ({1'b0, bus.addr_i} < DEPTH_L);
  assign idx      = bus.addr_i[IDX_W-1:0];

  // A response only counts while the cycle is alive; dropping cyc_i kills it at once.
  assign resp        = p_vld[LATENCY-1] & bus.cyc_i;
  assign bus.stall_o = (count == MAX_L) && !resp;
  assign accept      = bus.cyc_i & bus.stb_i & ~bus.stall_o;

  assign bus.ack_o = resp & ~p_err[LATENCY-1];
  assign bus.err_o = resp &  p_err[LATENCY-1];
  assign bus.dat_o = (resp && p_rd[LATENCY-1]) ? p_dat[LATENCY-1] : '0;

  // Memory has no reset so its contents survive both reset and cycle aborts.
  always_ff @(posedge clk) begin
    if (accept && bus.we_i && in_range) begin
      for (int b = 0; b < LANES; b++) begin
        if (bus.sel_i[b]) begin
          mem[idx][8*b +: 8] <= bus.dat_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_vld <= '0;
      p_err <= '0;
      p_rd  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        p_dat[i] <= '0;
      end
    end else if (!bus.cyc_i) begin
      p_vld <= '0;
      p_err <= '0;
      p_rd  <= '0;
    end else begin
      p_vld[0] <= accept;
      p_err[0] <= accept & ~in_range;
      p_rd[0]  <= accept & ~bus.we_i & in_range;
      p_dat[0] <= (accept && !bus.we_i && in_range) ? mem[idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        p_vld[i] <= p_vld[i-1];
        p_err[i] <= p_err[i-1];
        p_rd[i]  <= p_rd[i-1];
        p_dat[i] <= p_dat[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!bus.cyc_i) begin
      count <= '0;
    end else if (accept && !resp) begin
      count <= count + CW'(1);
    end else if (!accept && resp) begin
      count <= count - CW'(1);
    end
  end
endmodule

// File: doc/mr_wb_sram.md
MR_WB_SRAM -- requirements
Module: mr_wb_sram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of XLEN-bit words stored (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request acceptance to ack_o/err_o (legal 1..4).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered requests (legal 1..LATENCY+1).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port: clk  input  1  rising-edge clock.
REQ-006 SHALL have port: rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: cyc_i  input  1  Wishbone cycle.
REQ-008 SHALL have port: stb_i  input  1  Wishbone strobe.
REQ-009 SHALL have port: we_i  input  1  write enable.
REQ-010 SHALL have port: addr_i  input  XLEN-XLEN_GRAN  word address.
REQ-011 SHALL have port: sel_i  input  XLEN/8  byte lane selects.
REQ-012 SHALL have port: dat_i  input  XLEN  write data.
REQ-013 SHALL have port: ack_o  output  1  request completed.
REQ-014 SHALL have port: err_o  output  1  request failed.
REQ-015 SHALL have port: stall_o  output  1  request not accepted this cycle.
REQ-016 SHALL have port: dat_o  output  XLEN  read data.

Function
REQ-017 SHALL accept a request on a rising edge where cyc_i, stb_i and !stall_o are all high; at most one per cycle.
REQ-018 SHALL assert stall_o combinationally when outstanding count == MAX_OUTSTANDING and no response is issued that cycle; otherwise deassert it.
REQ-019 SHALL flag an accepted request out-of-range when addr_i >= DEPTH_WORDS.
REQ-020 SHALL commit an in-range write at the acceptance edge, updating only the byte lanes with sel_i set; sel_i == 0 writes nothing but still acks.
REQ-021 SHALL never write memory for out-of-range requests.
REQ-022 SHALL capture in-range read data at the acceptance edge; a read accepted the cycle after a write to the same word returns the new data.
REQ-023 SHALL issue exactly one response per accepted request, exactly LATENCY cycles after acceptance, in acceptance order.
REQ-024 SHALL respond with err_o for out-of-range requests and ack_o otherwise; ack_o and err_o never high together.
REQ-025 SHALL drive dat_o with read data only in an ack_o cycle of a read; dat_o SHALL be 0 in all other cycles.
REQ-026 SHALL keep an outstanding counter: +1 on accept, -1 on response, unchanged on simultaneous accept and response.
REQ-027 SHALL abort on cyc_i low: flush all in-flight responses, zero the counter, suppress ack_o/err_o from that cycle on; committed writes stay.
REQ-028 SHALL ignore stb_i while cyc_i is low.
REQ-029 SHALL keep ack_o and err_o low while cyc_i is low.

Reset
REQ-030 SHALL, while rst is low, force ack_o=0, err_o=0, stall_o=0, dat_o=0, outstanding count 0 and the response pipeline empty, asynchronously.
REQ-031 SHALL not clear memory contents on reset; reset mid-transaction drops pending responses, and a write accepted before reset stays committed.
REQ-032 SHALL accept requests from the first rising edge after rst deasserts.

Verification
REQ-033 Write addr 5, dat 0xDEADBEEF, sel 4'b1111; then read addr 5 -> ack_o exactly LATENCY cycles after each accept, read dat_o = 0xDEADBEEF.
REQ-034 Write addr 5, dat 0x11223344, sel 4'b0101 over 0xDEADBEEF; read -> 0xDE22BE44.
REQ-035 LATENCY=3, MAX_OUTSTANDING=2, stb_i held high with four back-to-back reads -> stall_o high on the 3rd request cycle, 4 in-order acks, count never exceeds 2.
REQ-036 Read addr DEPTH_WORDS -> err_o pulse after LATENCY, ack_o low, dat_o 0; a following write there leaves address 0 unchanged.
REQ-037 Two reads accepted, then cyc_i dropped before their responses -> no ack_o/err_o; new cycle next clock accepted immediately with count 0.
REQ-038 rst pulsed low with one write in flight -> outputs 0 at once, no response after release; reading that address returns the written data.
